dmem_responder: RTL

//   Memory-side responder for the CPU data-memory port (addr, width, signext, read/write,

---
 rtl/dmem_responder.sv | 86 ++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with valid/ready request, fixed access latency and held response
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_width,
  input  logic              req_signext,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              wr_q, sx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        width_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [2**(ADDR_W-2)];
  logic [31:0]       word, sh, ld, wrep, mask, merged;
  logic [3:0]        be;
  logic              err, fire;
  assign req_ready = state == IDLE;
  assign fire = state == WAIT && cnt == 4'd0;
  assign word = mem[addr_q[ADDR_W-1:2]];
  always_comb begin
    err = width_q == 2'd3 || (width_q == 2'd1 && addr_q[0]) || (width_q == 2'd2 && addr_q[1:0] != 2'd0);
    be = width_q == 2'd0 ? 4'b0001 << addr_q[1:0] : width_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    wrep = width_q == 2'd0 ? {4{wdata_q[7:0]}} : width_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    merged = (word & ~mask) | (wrep & mask);
    sh = word >> {addr_q[1:0], 3'b000};
    ld = width_q == 2'd0 ? {{24{sx_q & sh[7]}}, sh[7:0]} : width_q == 2'd1 ? {{16{sx_q & sh[15]}}, sh[15:0]} : word;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      sx_q      <= 1'b0;
      addr_q    <= '0;
      width_q   <= 2'd0;
      wdata_q   <= 32'd0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        wr_q    <= req_write;
        sx_q    <= req_signext;
        addr_q  <= req_addr;
        width_q <= req_width;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
        state   <= WAIT;
      end
    end else if (state == WAIT) begin
      if (cnt == 4'd0) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (err || wr_q) ? 32'd0 : ld;
        rsp_err   <= err;
        state     <= RESP;
      end else
        cnt <= cnt - 4'd1;
    end else if (state == RESP) begin
      if (rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
        state     <= IDLE;
      end
    end else
      state <= IDLE;
  end
  // Array has no reset; gating on reset keeps an aborted store from committing
  always_ff @(posedge clock)
    if (!reset && fire && wr_q && !err) mem[addr_q[ADDR_W-1:2]] <= merged;
endmodule
